// File: rtl/wb_mem_responder_pkg.sv
// Shared definitions for the wishbone memory responder: FSM state encoding,
// bus field widths and the word-index range check.
package wb_mem_responder_pkg;

  localparam int WB_SEL_WIDTH  = 4;
  localparam int WB_ADR_WIDTH  = 32;
  localparam int WB_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_resp_state_e;

  // True when a word index falls outside a memory of 'depth' words.
  // The index is compared in full, so high address bits never alias.
  function automatic logic wb_out_of_range(input logic [WB_ADR_WIDTH-3:0] word_idx,
                                           input int unsigned depth);
    return ({2'b00, word_idx} >= depth);
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic wishbone bus bundle shared by the core (master) and its responders.
interface wishbone_if #(
  parameter int DW = 32
);
  import wb_mem_responder_pkg::*;

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [WB_ADR_WIDTH-1:0] adr;
  logic [DW-1:0]           datwr;
  logic [DW-1:0]           datrd;
  logic [WB_SEL_WIDTH-1:0] sel;
  logic                    ack;

  modport master (
    output cyc, stb, we, adr, datwr, sel,
    input  datrd, ack
  );

  modport slave (
    input  cyc, stb, we, adr, datwr, sel,
    output datrd, ack
  );

endinterface

// File: rtl/wb_mem_responder_byte_ram.sv
// Single-port synchronous RAM with per-byte write enables. The read register
// only loads when re_i is high, so a read result stays stable until the next
// read is issued. Contents are never reset.
module wb_byte_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  re_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write; a read sees the word as it stood before this edge
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LANES; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone memory responder: accepts one request at a time in IDLE, optionally
// inserts WAIT_STATES wait cycles, then pulses ack for one cycle. Writes land
// on the edge that enters ACK; read data is taken at acceptance and presented
// registered alongside ack. Out-of-range accesses complete normally but are
// suppressed and latch a sticky range_err.
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int data_width  = 32
) (
  input  logic      clk,
  input  logic      rst,
  wishbone_if.slave bus,
  output logic      range_err
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LANES = data_width / 8;
  localparam logic [WB_WAIT_CNT_W-1:0] WAIT_LOAD = WB_WAIT_CNT_W'(WAIT_STATES);

  wb_resp_state_e           state_q, state_d;
  logic [WB_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                     go_ack;

  logic                     ack_q;
  logic [data_width-1:0]    datrd_q;
  logic                     range_err_q;

  logic                     we_q;
  logic                     oor_q;
  logic [AW-1:0]            idx_q;
  logic [data_width-1:0]    datwr_q;
  logic [LANES-1:0]         sel_q;

  logic                     req;
  logic                     in_idle;
  logic                     in_oor;
  logic [AW-1:0]            in_idx;
  logic                     eff_we;
  logic                     eff_oor;
  logic [LANES-1:0]         eff_sel;
  logic [AW-1:0]            ram_addr;
  logic                     ram_re;
  logic [LANES-1:0]         ram_be;
  logic [data_width-1:0]    ram_wdata;
  logic [data_width-1:0]    ram_rdata;
  logic                     unused_adr_lsb;

  assign req            = bus.cyc & bus.stb;
  assign in_idle        = (state_q == WB_IDLE);
  assign in_idx         = bus.adr[AW+1:2];
  assign in_oor         = wb_out_of_range(bus.adr[WB_ADR_WIDTH-1:2], DEPTH_WORDS);
  assign unused_adr_lsb = ^bus.adr[1:0];

  // With no wait states the ACK-entry edge is the acceptance edge itself, so
  // the live bus fields are used; otherwise the captured copies are used.
  assign eff_we    = in_idle ? bus.we    : we_q;
  assign eff_oor   = in_idle ? in_oor    : oor_q;
  assign eff_sel   = in_idle ? bus.sel   : sel_q;
  assign ram_addr  = in_idle ? in_idx    : idx_q;
  assign ram_wdata = in_idle ? bus.datwr : datwr_q;

  // Memory is not reset, so its strobes are held off while rst is low.
  assign ram_be = (rst && go_ack && eff_we && !eff_oor) ? eff_sel : '0;
  assign ram_re = rst && in_idle && req && !bus.we && !in_oor;

  wb_byte_ram #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (data_width),
    .ADDR_W (AW)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr),
    .re_i    (ram_re),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, abort on a dropped strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_ack  = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = WB_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WB_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WB_WAIT: begin
        if (!req) begin
          state_d = WB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            state_d = WB_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      WB_ACK: begin
        state_d = WB_IDLE;
      end
      default: begin
        state_d = WB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completion outputs trail the ACK state by one cycle; range_err is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q       <= 1'b0;
      datrd_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      ack_q       <= (state_q == WB_ACK);
      datrd_q     <= (state_q == WB_ACK && !we_q && !oor_q) ? ram_rdata : '0;
      range_err_q <= range_err_q | (go_ack & eff_oor);
    end
  end

  // Request capture at the acceptance edge
  always_ff @(posedge clk) begin
    if (in_idle && req) begin
      we_q    <= bus.we;
      oor_q   <= in_oor;
      idx_q   <= in_idx;
      datwr_q <= bus.datwr;
      sel_q   <= bus.sel;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.datrd = datrd_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: a zero-wait-state instance driven from a
// vector table plus hand sequences, and a three-wait-state instance for
// latency, abort and mid-transfer reset.
module tb_wb_mem_responder;
  import wb_mem_responder_pkg::*;

  logic clk;
  logic rst0, rst3;
  logic re0, re3;
  int   checks;
  int   failures;

  wishbone_if bus0 ();
  wishbone_if bus3 ();

  wb_mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (0),
    .data_width  (32)
  ) dut0 (
    .clk       (clk),
    .rst       (rst0),
    .bus       (bus0),
    .range_err (re0)
  );

  wb_mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (3),
    .data_width  (32)
  ) dut3 (
    .clk       (clk),
    .rst       (rst3),
    .bus       (bus3),
    .range_err (re3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic        exp_rerr;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [31:0] b2b_exp [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] dw, input logic [3:0] sl);
    if (d == 0) begin
      bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.datwr = dw; bus0.sel = sl;
    end else begin
      bus3.cyc = c; bus3.stb = s; bus3.we = w; bus3.adr = a; bus3.datwr = dw; bus3.sel = sl;
    end
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus0.ack : bus3.ack;
  endfunction

  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? bus0.datrd : bus3.datrd;
  endfunction

  // Called at a negedge. k = number of negedges after the acceptance edge at
  // which ack was first seen (-1 if never); ack_after = ack one cycle later.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dw,
                      input logic [3:0] sl, output logic [31:0] rd, output int k,
                      output logic ack_after);
    rd = '0;
    k  = -1;
    drive(d, 1'b1, 1'b1, w, a, dw, sl);
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (get_ack(d)) begin
        k  = i;
        rd = get_rd(d);
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    ack_after = get_ack(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    int          k;
    logic        aa;
    int          nack;
    logic        e;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF,  1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0,          1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_AA00, 4'b0010, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h1122_AA44,  1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0,          1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h1122_AA44,  1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'b1111, 32'h0,          1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'b1001, 32'h0,          1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0027, 32'h0,         4'b0000, 32'hA500_00A5,  1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h1234_5678,  1'b0};
    vecs[12] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'h0,          1'b0};
    vecs[13] = '{1'b1, 32'h0000_0004, 32'h0102_0304, 4'b1111, 32'h0,          1'b0};
    vecs[14] = '{1'b1, 32'h0000_0008, 32'h0A0B_0C0D, 4'b1111, 32'h0,          1'b0};
    vecs[15] = '{1'b1, 32'h0000_1000, 32'h5555_5555, 4'b1111, 32'h0,          1'b1};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hCAFE_F00D,  1'b1};
    vecs[17] = '{1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'h0,          1'b1};
    vecs[18] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF,  1'b1};

    b2b_exp[0] = 32'hCAFE_F00D;
    b2b_exp[1] = 32'h0102_0304;
    b2b_exp[2] = 32'h0A0B_0C0D;

    // Reset asserted before any clock edge: outputs must clear asynchronously
    rst0 = 1'b1;
    rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    #2;
    chk("rst_ack0",   {31'b0, bus0.ack}, 32'd0);
    chk("rst_datrd0", bus0.datrd,        32'd0);
    chk("rst_rerr0",  {31'b0, re0},      32'd0);
    chk("rst_ack3",   {31'b0, bus3.ack}, 32'd0);
    chk("rst_datrd3", bus3.datrd,        32'd0);
    chk("rst_rerr3",  {31'b0, re3},      32'd0);
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    rst3 = 1'b1;
    @(negedge clk);

    // Zero-wait-state vector table
    for (int i = 0; i < NV; i++) begin
      xfer(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, k, aa);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'd2);
      if (!vecs[i].we) chk($sformatf("v%0d_datrd", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_range_err", i), {31'b0, re0}, {31'b0, vecs[i].exp_rerr});
      chk($sformatf("v%0d_ack_pulse", i), {31'b0, aa}, 32'd0);
    end

    // Back-to-back reads with stb held: acks on alternate cycles
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, '0, '0);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = (i % 2 == 1);
      chk($sformatf("b2b_ack%0d", i), {31'b0, bus0.ack}, {31'b0, e});
      if (e) chk($sformatf("b2b_datrd%0d", i), bus0.datrd, b2b_exp[i/2]);
      else   chk($sformatf("b2b_datrd_idle%0d", i), bus0.datrd, 32'd0);
      if (i == 1) bus0.adr = 32'h4;
      if (i == 3) bus0.adr = 32'h8;
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);

    // Write immediately followed by a read of the same word
    drive(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h7766_5544, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wr_rd_wack", {31'b0, bus0.ack}, 32'd1);
    bus0.we = 1'b0;
    @(negedge clk);
    chk("wr_rd_gap", {31'b0, bus0.ack}, 32'd0);
    @(negedge clk);
    chk("wr_rd_rack",  {31'b0, bus0.ack}, 32'd1);
    chk("wr_rd_datrd", bus0.datrd, 32'h7766_5544);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);

    // Three wait states: write then read latency
    xfer(3, 1'b1, 32'h40, 32'h1357_9BDF, 4'b1111, rd, k, aa);
    chk("ws3_wr_latency", 32'(k), 32'd5);
    chk("ws3_wr_pulse", {31'b0, aa}, 32'd0);
    xfer(3, 1'b0, 32'h40, '0, '0, rd, k, aa);
    chk("ws3_rd_latency", 32'(k), 32'd5);
    chk("ws3_rd_datrd", rd, 32'h1357_9BDF);

    // Strobe dropped in the second wait cycle of a write
    drive(3, 1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    bus3.stb = 1'b0;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.ack) nack++;
    end
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("abort_noack", 32'(nack), 32'd0);
    xfer(3, 1'b0, 32'h40, '0, '0, rd, k, aa);
    chk("abort_mem_kept", rd, 32'h1357_9BDF);

    // Preload a target word and raise range_err on this instance
    xfer(3, 1'b1, 32'h44, 32'h0BAD_C0DE, 4'b1111, rd, k, aa);
    xfer(3, 1'b1, 32'h1000, 32'h5555_5555, 4'b1111, rd, k, aa);
    chk("ws3_oor_latency", 32'(k), 32'd5);
    chk("ws3_oor_rerr", {31'b0, re3}, 32'd1);

    // Asynchronous reset pulse while a write is waiting
    drive(3, 1'b1, 1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst3 = 1'b0;
    #1;
    chk("midrst_ack",   {31'b0, bus3.ack}, 32'd0);
    chk("midrst_rerr",  {31'b0, re3},      32'd0);
    chk("midrst_datrd", bus3.datrd,        32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus3.ack) nack++;
    end
    chk("midrst_noack", 32'(nack), 32'd0);
    xfer(3, 1'b0, 32'h44, '0, '0, rd, k, aa);
    chk("midrst_latency",  32'(k), 32'd5);
    chk("midrst_mem_kept", rd, 32'h0BAD_C0DE);
    chk("midrst_rerr_after", {31'b0, re3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
